// File: rtl/pair_sum_datapath.sv
// Two-RAM pairwise-sum datapath: words loaded into RAM A are summed two at a
// time through a hold register and stored into RAM B, with a sticky done flag.
module pair_sum_datapath #(
   parameter int DATA_W  = 8,
   parameter int A_DEPTH = 8,
   parameter int B_DEPTH = 4,
   localparam int AW     = $clog2(A_DEPTH),
   localparam int BW     = $clog2(B_DEPTH)
) (
   input  logic              clock,
   input  logic              Reset,
   input  logic              IncA,
   input  logic              IncB,
   input  logic              WEA,
   input  logic              WEB,
   input  logic [DATA_W-1:0] DataIn,
   output logic [AW-1:0]     AddrA,
   output logic [BW-1:0]     AddrB,
   output logic [DATA_W-1:0] DataOutA,
   output logic [DATA_W:0]   DataOutB,
   output logic [DATA_W:0]   Sum,
   output logic              Done
);

   localparam int CW = BW + 1;
   localparam logic [CW-1:0] B_FULL = CW'(B_DEPTH);

   logic [DATA_W-1:0] memA_q [A_DEPTH];
   logic [DATA_W:0]   memB_q [B_DEPTH];

   logic [AW-1:0]     addrA_q, addrA_d;
   logic [BW-1:0]     addrB_q, addrB_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [CW-1:0]     wrCount_q, wrCount_d;

   assign AddrA    = addrA_q;
   assign AddrB    = addrB_q;
   assign DataOutA = memA_q[addrA_q];
   assign DataOutB = memB_q[addrB_q];
   assign Sum      = {1'b0, hold_q} + {1'b0, DataOutA};
   assign Done     = (wrCount_q == B_FULL);

   // Depths are powers of two, so the counters wrap naturally at their width.
   // Hold only captures on a pure step so a load pass never disturbs it.
   always_comb begin
      addrA_d   = addrA_q;
      addrB_d   = addrB_q;
      hold_d    = hold_q;
      wrCount_d = wrCount_q;
      if (IncA) begin
         addrA_d = addrA_q + AW'(1);
      end
      if (IncB) begin
         addrB_d = addrB_q + BW'(1);
      end
      if (IncA && !WEA) begin
         hold_d = DataOutA;
      end
      if (WEB && !Done) begin
         wrCount_d = wrCount_q + CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (Reset) begin
         addrA_q   <= '0;
         addrB_q   <= '0;
         hold_q    <= '0;
         wrCount_q <= '0;
      end else begin
         addrA_q   <= addrA_d;
         addrB_q   <= addrB_d;
         hold_q    <= hold_d;
         wrCount_q <= wrCount_d;
      end
   end

   // RAM contents survive reset, but reset still suppresses writes that cycle.
   always_ff @(posedge clock) begin
      if (!Reset && WEA) begin
         memA_q[addrA_q] <= DataIn;
      end
      if (!Reset && WEB) begin
         memB_q[addrB_q] <= Sum;
      end
   end

endmodule

// File: tb/tb_pair_sum_datapath.sv
// Directed-vector bench for pair_sum_datapath with hand-computed expectations.
module tb_pair_sum_datapath;

   logic       clock;
   logic       Reset;
   logic       IncA, IncB, WEA, WEB;
   logic [7:0] DataIn;
   logic [2:0] AddrA;
   logic [1:0] AddrB;
   logic [7:0] DataOutA;
   logic [8:0] DataOutB;
   logic [8:0] Sum;
   logic       Done;

   int vectorCount;
   int miscompareCount;

   pair_sum_datapath #(.DATA_W(8), .A_DEPTH(8), .B_DEPTH(4)) dut (
      .clock    (clock),
      .Reset    (Reset),
      .IncA     (IncA),
      .IncB     (IncB),
      .WEA      (WEA),
      .WEB      (WEB),
      .DataIn   (DataIn),
      .AddrA    (AddrA),
      .AddrB    (AddrB),
      .DataOutA (DataOutA),
      .DataOutB (DataOutB),
      .Sum      (Sum),
      .Done     (Done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive one cycle of strobes, then sample 1 time unit after the edge.
   task automatic applyStimulus(input logic rst, input logic incA, input logic incB,
                                input logic weA, input logic weB, input logic [7:0] din);
      Reset  = rst;
      IncA   = incA;
      IncB   = incB;
      WEA    = weA;
      WEB    = weB;
      DataIn = din;
      @(posedge clock);
      #1;
      Reset = 1'b0;
      IncA  = 1'b0;
      IncB  = 1'b0;
      WEA   = 1'b0;
      WEB   = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         miscompareCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   initial begin
      vectorCount     = 0;
      miscompareCount = 0;
      Reset = 1'b1; IncA = 1'b0; IncB = 1'b0; WEA = 1'b0; WEB = 1'b0; DataIn = 8'h00;
      #2;

      // Reset with all strobes high must not write or step anything.
      applyStimulus(1, 0, 0, 0, 0, 8'h00);
      applyStimulus(0, 0, 0, 1, 0, 8'h5A);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 0, 8'h00);
      checkOutput("preResetAddrA", AddrA, 3);
      checkOutput("preResetAddrB", AddrB, 3);
      applyStimulus(1, 1, 1, 1, 1, 8'hA5);
      applyStimulus(1, 1, 1, 1, 1, 8'hA5);
      checkOutput("resetAddrA", AddrA, 0);
      checkOutput("resetAddrB", AddrB, 0);
      checkOutput("resetDone", Done, 0);
      checkOutput("resetMemA0", DataOutA, 8'h5A);
      checkOutput("resetSum", Sum, 9'h05A);

      // Load eight words, address wraps back to 0.
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 1, 0, 8'((i + 1) * 10));
      checkOutput("loadAddrA", AddrA, 0);
      checkOutput("loadDataOutA", DataOutA, 10);
      checkOutput("loadSumHold0", Sum, 10);

      // Pairwise reduce into RAM B.
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 1, 0, 0, 0, 8'h00);
         checkOutput($sformatf("reduceSum%0d", k), Sum, 30 + 40 * k);
         checkOutput($sformatf("reduceDoneBefore%0d", k), Done, 0);
         applyStimulus(0, 1, 1, 0, 1, 8'h00);
      end
      checkOutput("reduceDone", Done, 1);
      checkOutput("reduceAddrA", AddrA, 0);
      checkOutput("reduceAddrB", AddrB, 0);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("reduceMemB%0d", k), DataOutB, 30 + 40 * k);
         applyStimulus(0, 0, 1, 0, 0, 8'h00);
      end
      checkOutput("doneSticky", Done, 1);

      // Reset mid-operation keeps RAM B and restarts the write count.
      applyStimulus(1, 0, 0, 0, 0, 8'h00);
      checkOutput("midResetAddrB", AddrB, 0);
      checkOutput("midResetDone", Done, 0);
      checkOutput("midResetMemB0", DataOutB, 30);
      applyStimulus(0, 0, 1, 0, 0, 8'h00);
      checkOutput("midResetMemB1", DataOutB, 70);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 0, 1, 0, 1, 8'h00);
         checkOutput($sformatf("rewriteDone%0d", k), Done, 0);
      end
      applyStimulus(0, 0, 1, 0, 1, 8'h00);
      checkOutput("rewriteDone3", Done, 1);
      checkOutput("rewriteAddrB", AddrB, 1);
      checkOutput("rewriteMemB1", DataOutB, 10);
      applyStimulus(0, 0, 0, 0, 1, 8'h00);
      checkOutput("saturateDone", Done, 1);

      // Full-scale operands produce a 9-bit sum.
      applyStimulus(0, 0, 0, 1, 0, 8'hFF);
      applyStimulus(0, 1, 0, 0, 0, 8'h00);
      applyStimulus(0, 0, 0, 1, 0, 8'hFF);
      checkOutput("overflowSum", Sum, 9'h1FE);
      applyStimulus(0, 0, 0, 0, 1, 8'h00);
      checkOutput("overflowMemB", DataOutB, 9'h1FE);
      checkOutput("holdAddrA", AddrA, 1);

      // Every strobe at once: writes land on pre-increment addresses.
      applyStimulus(0, 1, 0, 0, 0, 8'h00);
      checkOutput("collideAddrA", AddrA, 2);
      checkOutput("collideAddrB", AddrB, 1);
      checkOutput("collideSumPre", Sum, 285);
      applyStimulus(0, 1, 1, 1, 1, 8'h33);
      checkOutput("collideAddrAPost", AddrA, 3);
      checkOutput("collideAddrBPost", AddrB, 2);
      checkOutput("collideHoldKept", Sum, 295);
      for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 0, 0, 8'h00);
      checkOutput("collideMemA2", DataOutA, 8'h33);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 8'h00);
      checkOutput("collideMemB1", DataOutB, 285);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $finish;
   end

endmodule

// File: doc/pair_sum_datapath.md
# pair_sum_datapath

Datapath stage driven directly by the sequencing controller's IncA, IncB, WEA and WEB strobes. It owns two address counters and two RAMs:
- RAM A is loaded with eight input words.
- Adjacent A entries are summed pairwise.
- The sums are written into RAM B.

A sticky Done flag marks completion of four B writes.

## Interface
- DATA_W, 8, width of input words and RAM A entries
- A_DEPTH, 8, RAM A entries (power of two); AddrA width = log2(A_DEPTH)
- B_DEPTH, 4, RAM B entries (power of two); AddrB width = log2(B_DEPTH)
- clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- IncA  in  1  advance AddrA at end of cycle
- IncB  in  1  advance AddrB at end of cycle
- WEA  in  1  write DataIn to RAM A at AddrA
- WEB  in  1  write Sum to RAM B at AddrB
- DataIn  in  DATA_W  word to store in RAM A
- AddrA  out  log2(A_DEPTH)  current RAM A address
- AddrB  out  log2(B_DEPTH)  current RAM B address
- DataOutA  out  DATA_W  RAM A contents at AddrA
- DataOutB  out  DATA_W+1  RAM B contents at AddrB
- Sum  out  DATA_W+1  Hold + DataOutA, zero-extended
- Done  out  1  high once B_DEPTH writes to RAM B have completed since reset

## Operation
- **RAM A:** A_DEPTH x DATA_W.
  - When WEA=1, memA[AddrA] <= DataIn at the clock edge.
  - Read is combinational: DataOutA = memA[AddrA].
- **RAM B:** B_DEPTH x (DATA_W+1).
  - When WEB=1, memB[AddrB] <= Sum at the clock edge.
  - Read is combinational: DataOutB = memB[AddrB].
- **AddrA:** when IncA=1, AddrA <= AddrA+1, wrapping A_DEPTH-1 -> 0. Otherwise it holds.
- **AddrB:** when IncB=1, AddrB <= AddrB+1, wrapping B_DEPTH-1 -> 0. Otherwise it holds.
- **Hold register (DATA_W):** when IncA=1 and WEA=0, Hold <= DataOutA. It captures the element being stepped past, so after one IncA step Sum = A[k-1] + A[k].
- **Sum:** Sum = {1'b0,Hold} + {1'b0,DataOutA}. The result is DATA_W+1 bits and never overflows; maximum 2*(2^DATA_W - 1).
- **WrCount:** counts WEB writes, saturating at B_DEPTH. Done = (WrCount == B_DEPTH). Done is sticky until Reset; further WEB writes still occur and wrap AddrB normally.
- **Reset=1:** AddrA=0, AddrB=0, Hold=0, WrCount=0, Done=0 at the next edge.
  - RAM contents are not cleared.
  - Reset overrides every strobe in the same cycle: no write, no increment.
- **Simultaneous events:**
  - WEA+IncA in the same cycle: write goes to the pre-increment AddrA.
  - WEB+IncB in the same cycle: write goes to the pre-increment AddrB, using Sum from that cycle.
  - WEA and WEB in the same cycle are both honoured independently.
- Inputs are taken as-is; any strobe combination is legal.

## Timing
- Write latency is 1 cycle: data written at edge N is visible on DataOutA/B from N onward when the address matches.
- Read latency is 0 cycles: combinational from address.
- Address update takes 1 cycle: AddrA/AddrB change at the edge where the strobe was sampled high.
- Done rises at the edge that performs the B_DEPTH-th write.
- Reset state of outputs:
  - AddrA=0, AddrB=0, Done=0.
  - Sum = DataOutA, since Hold=0.
  - DataOutA/DataOutB are undefined until the addressed entry is written; the bench must not check unwritten entries.

## Test plan
1. **Reset:** arbitrary state, Reset=1 for 2 cycles with all strobes high -> AddrA=0, AddrB=0, Done=0; no RAM entry is modified.
2. **Load A:** WEA=IncA=1 for 8 cycles, DataIn=10,20,...,80 -> memA[0..7] = 10..80, AddrA wraps to 0, DataOutA=10.
3. **Pairwise reduce:** from test 2's state, repeat four times the sequence IncA (cycle), WEB+IncB+IncA (cycle).
   - Expected memB[0..3] = 30, 70, 110, 150.
   - AddrB returns to 0.
   - Done=1 after the 4th write.
4. **Overflow width:** load memA[0]=255, memA[1]=255, then IncA, then WEB -> memB[0]=510 (9'h1FE); Sum is never truncated.
5. **Reset mid-operation:** after two B writes (memB[0]=30, memB[1]=70), pulse Reset.
   - Expected: AddrB=0, WrCount=0, Done=0; memB[0]=30 and memB[1]=70 are retained.
   - Four further writes are required before Done rises again.
6. **Strobe collision:** WEA=WEB=IncA=IncB=1 in one cycle at AddrA=2, AddrB=1.
   - Expected: memA[2]=DataIn and memB[1]=Sum, both at the pre-increment addresses.
   - Then AddrA=3, AddrB=2, and Hold is unchanged because WEA=1.
